// File: rtl/fetch_sequencer_if.sv
// Handshake/bus bundle between the fetch sequencer and its controller.
interface fetch_sequencer_if #(
  parameter int PC_W = 8
);
  logic            start_i;
  logic [PC_W-1:0] start_addr_i;
  logic            halt_i;
  logic            stall_i;
  logic            jump_i;
  logic            jump_rel_i;
  logic [PC_W-1:0] target_i;
  logic            call_i;
  logic            ret_i;
  logic [PC_W-1:0] pc_o;
  logic            valid_o;
  logic            halted_o;
  logic            stack_empty_o;
  logic            stack_full_o;
  logic            err_o;

  modport master (
    output start_i, start_addr_i, halt_i, stall_i, jump_i, jump_rel_i,
           target_i, call_i, ret_i,
    input  pc_o, valid_o, halted_o, stack_empty_o, stack_full_o, err_o
  );

  modport slave (
    input  start_i, start_addr_i, halt_i, stall_i, jump_i, jump_rel_i,
           target_i, call_i, ret_i,
    output pc_o, valid_o, halted_o, stack_empty_o, stack_full_o, err_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer (IDLE/RUN/HALT) with optional return-address stack.
// Stack, call/return and the stack flags are built only when FETCH_RET_STACK_EN is defined.
module fetch_sequencer #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_i,
  fetch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

`ifdef FETCH_RET_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] FULL_CNT = SP_W'(STACK_DEPTH);

  logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d, sp_dec;
  logic [IDX_W-1:0] push_idx, top_idx;
  logic             err_q, err_d;
  logic             empty_q, full_q;
  logic             push;

  assign sp_dec   = sp_q - SP_W'(1);
  assign push_idx = sp_q[IDX_W-1:0];
  assign top_idx  = sp_dec[IDX_W-1:0];
`else
  logic unused_ret;
  assign unused_ret = bus.ret_i;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
`ifdef FETCH_RET_STACK_EN
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
`endif
    if (bus.start_i) begin
      state_d = RUN;
      pc_d    = bus.start_addr_i;
      valid_d = 1'b1;
`ifdef FETCH_RET_STACK_EN
      sp_d    = '0;
      err_d   = 1'b0;
`endif
    end else if (state_q == RUN) begin
      if (bus.halt_i) begin
        state_d = HALT;
        valid_d = 1'b0;
      end else if (bus.stall_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = 1'b1;
`ifdef FETCH_RET_STACK_EN
        if (bus.ret_i) begin
          // Popping an empty stack falls back to sequential fetch.
          if (sp_q == '0) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d = stack_mem[top_idx];
            sp_d = sp_dec;
          end
        end else if (bus.call_i) begin
          pc_d = bus.target_i;
          if (sp_q == FULL_CNT) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
          end
        end else
`else
        if (bus.call_i) begin
          pc_d = bus.target_i;
        end else
`endif
        if (bus.jump_i) begin
          // Same-width add gives sign-extended offset arithmetic modulo 2^PC_W.
          pc_d = bus.jump_rel_i ? (pc_q + bus.target_i) : bus.target_i;
        end else begin
          pc_d = pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
`ifdef FETCH_RET_STACK_EN
      sp_q    <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
`ifdef FETCH_RET_STACK_EN
      sp_q    <= sp_d;
      err_q   <= err_d;
      empty_q <= (sp_d == '0);
      full_q  <= (sp_d == FULL_CNT);
`endif
    end
  end

`ifdef FETCH_RET_STACK_EN
  // Contents are don't-care once sp is reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign bus.stack_empty_o = empty_q;
  assign bus.stack_full_o  = full_q;
  assign bus.err_o         = err_q;
`else
  assign bus.stack_empty_o = 1'b1;
  assign bus.stack_full_o  = 1'b0;
  assign bus.err_o         = 1'b0;
`endif

  assign bus.pc_o     = pc_q;
  assign bus.valid_o  = valid_q;
  assign bus.halted_o = (state_q == HALT);

endmodule
